// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide (shift-add / restoring divide).
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready + op/a/b in,
// out_valid/out_ready + result out; busy. Optional macro: MD_EARLY_OUT_EN.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_nx;
  logic [XLEN-1:0]   mag;
  logic [2:0]        op_r;
  logic              neg_q, neg_r, div0;
  logic [XLEN-1:0]   fin;

  logic              accept, last;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept = in_valid & in_ready & ~flush;
  assign last   = (cnt == CNT_W'(XLEN - 1));

  assign a_signed = (op == 3'b001) | (op == 3'b010)
                  | (op == 3'b100) | (op == 3'b110);
  assign b_signed = (op == 3'b001) | (op == 3'b100)
                  | (op == 3'b110);
  assign a_neg = a_signed & a[XLEN-1];
  assign b_neg = b_signed & b[XLEN-1];
  // As unsigned XLEN-bit values these hold |most-negative| exactly,
  // so the 2*XLEN product of two magnitudes never overflows.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

`ifdef MD_EARLY_OUT_EN
  logic            early, ovf_in, b_zero;
  logic [XLEN-1:0] early_res;

  assign b_zero = (b == '0);
  assign ovf_in = ((op == 3'b100) | (op == 3'b110))
                & (a == {1'b1, {(XLEN-1){1'b0}}})
                & (&b);

  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (op[2]) begin
      early = b_zero | ovf_in;
      if (!op[1])
        early_res = b_zero ? '1 : a;
      else
        early_res = b_zero ? a : '0;
    end else begin
      early = (a == '0) | b_zero;
    end
  end
`else
  logic early;
  assign early = 1'b0;
`endif

  // One iteration of either algorithm.
  // Multiply: acc = {partial hi, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend/quotient bits}.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN+1:0] div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
             + (acc[0] ? {1'b0, mag} : '0);
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b0, mag};
    if (op_r[2]) begin
      if (!div_diff[XLEN+1])
        acc_nx = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_nx = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nx = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign fix-up and selection from the final accumulator.
  // A zero divisor leaves |a| in the remainder, so only the
  // quotient needs the all-ones override.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod = neg_q ? -acc_nx : acc_nx;
    quo  = acc_nx[XLEN-1:0];
    rem  = acc_nx[2*XLEN-1:XLEN];
    fin  = '0;
    unique case (1'b1)
      !op_r[2]: fin = (op_r[1:0] == 2'b00)
                    ? prod[XLEN-1:0]
                    : prod[2*XLEN-1:XLEN];
      op_r[2] & !op_r[1]:
        fin = div0 ? '1 : (neg_q ? -quo : quo);
      op_r[2] & op_r[1]:
        fin = neg_r ? -rem : rem;
      default: fin = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_nx = early ? DONE : BUSY;
        BUSY: if (last) state_nx = DONE;
        DONE: if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mag    <= '0;
      op_r   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      result <= '0;
    end else if (!flush) begin
      if (accept) begin
        op_r  <= op;
        cnt   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        div0  <= (b == '0);
        acc   <= {{XLEN{1'b0}}, op[2] ? a_mag : b_mag};
        mag   <= op[2] ? b_mag : a_mag;
`ifdef MD_EARLY_OUT_EN
        if (early) result <= early_res;
`endif
      end else if (state == BUSY) begin
        acc <= acc_nx;
        cnt <= cnt + CNT_W'(1);
        if (last) result <= fin;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: random + directed RV32M checks against an arithmetic model.
// Covers latency, backpressure hold, flush, reset and boundary operands.
module tb_mul_div_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, uy;
    logic [63:0] p;
    int xi, yi;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'b0, y});
    xi = x;
    yi = y;
    p = '0;
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN && y == 32'hFFFF_FFFF) return x;
        return xi / yi;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN && y == 32'hFFFF_FFFF) return 0;
        return xi % yi;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_model(input logic [2:0] f,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
`ifdef MD_EARLY_OUT_EN
    if (f[2]) begin
      if (y == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && x == MIN
          && y == 32'hFFFF_FFFF) return 1;
    end else if (x == 0 || y == 0) begin
      return 1;
    end
`endif
    return XLEN + 1;
  endfunction

  task automatic issue(input logic [2:0] f,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input int hold,
                       input string tag);
    int k;
    logic [31:0] exp;
    exp = model(f, x, y);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "/rdy"}, 32'(in_ready), 32'd1);
    op = f; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    k = 1;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "/lat"}, 32'(k), 32'(lat_model(f, x, y)));
    check({tag, "/res"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_res"}, result, exp);
      check({tag, "/hold_flags"},
            32'({out_valid, in_ready, busy}), 32'b101);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/idle"}, 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  logic [2:0]  d_op [16];
  logic [31:0] d_a  [16];
  logic [31:0] d_b  [16];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return MIN;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset/flags", 32'({out_valid, in_ready, busy}), 32'b010);
    check("reset/result", result, 32'h0);
    rst = 1'b0;

    d_op = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6,
             3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd1, 3'd0};
    d_a  = '{32'd7, MIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'd5, 32'd5, MIN, MIN,
             32'hFFFF_FFFF, 32'd9, 32'd0, 32'd0};
    d_b  = '{32'hFFFF_FFFD, MIN, 32'hFFFF_FFFF, 32'd2,
             32'd7, 32'd7, 32'd2, 32'd2,
             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'd0, 32'd0, 32'd5, 32'd5};
    for (int i = 0; i < 16; i++)
      issue(d_op[i], d_a[i], d_b[i], 0, $sformatf("dir%0d", i));

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 10, "bp");
    issue(3'd5, 32'd100, 32'd7, 0, "b2b");

    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick(),
            $urandom_range(0, 2), $sformatf("rnd%0d", i));

    // flush during busy iteration 5 while a new op is offered
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush/flags", 32'({out_valid, in_ready, busy}), 32'b010);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("flush/quiet", 32'(seen), 32'd0);

    // reset mid-operation
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "pre_rst");
    @(negedge clk);
    op = 3'd4; a = 32'd77; b = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst/flags", 32'({out_valid, in_ready, busy}), 32'b010);
    check("rst/result", result, 32'h0);
    rst = 1'b0;
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
